// File: rtl/video_modulator_pkg.sv
// Shared types and default widths for the video modulator divider pair.
package video_modulator_pkg;

    // Divider control FSM; StRound is only entered when rounding is built in.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRound,
        StDone
    } vm_div_state_e;

    localparam int unsigned VM_DIV_DIVIDEND_W = 16;
    localparam int unsigned VM_DIV_DIVISOR_W  = 8;

endpackage

// File: rtl/video_modulator_div_lane.sv
// One lane of the restoring divider: partial remainder, dividend/quotient
// shift register, trial subtractor and divisor-zero detect.
// VIDEO_MODULATOR_DIV_ROUND_EN selects rounded results from the settled state;
// otherwise the results are the truncated values the final step produces.
module video_modulator_div_lane
    import video_modulator_pkg::*;
#(
    parameter int unsigned DividendW = VM_DIV_DIVIDEND_W,
    parameter int unsigned DivisorW  = VM_DIV_DIVISOR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [DividendW-1:0] dividend_i,
    input  logic [DivisorW-1:0]  divisor_i,
    output logic [DividendW-1:0] quot_res_o,
    output logic [DivisorW-1:0]  rem_res_o,
    output logic                 div_zero_o
);

    // Dividend bits shift out of the MSB while quotient bits fill the LSB,
    // so after DividendW steps this register holds the quotient.
    logic [DividendW-1:0] dvd_q, dvd_step;
    logic [DivisorW-1:0]  dsr_q;
    logic [DivisorW:0]    rem_q, rem_step;
    logic [DivisorW+1:0]  shifted, trial;
    logic                 qbit;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    always_comb begin
        shifted    = {rem_q, dvd_q[DividendW-1]};
        trial      = shifted - {2'b00, dsr_q};
        qbit       = ~trial[DivisorW+1];
        rem_step   = qbit ? trial[DivisorW:0] : shifted[DivisorW:0];
        dvd_step   = {dvd_q[DividendW-2:0], qbit};
        div_zero_o = (dsr_q == '0);
    end

    // Operand latch on load, iteration on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            dvd_q <= dividend_i;
            dsr_q <= divisor_i;
            rem_q <= '0;
        end else if (step_i) begin
            dvd_q <= dvd_step;
            rem_q <= rem_step;
        end
    end

`ifdef VIDEO_MODULATOR_DIV_ROUND_EN
    logic round_up;

    // Round half up from the settled state, saturating at all ones.
    always_comb begin
        round_up = ({rem_q, 1'b0} >= {2'b00, dsr_q});
        if (div_zero_o) begin
            quot_res_o = '1;
            rem_res_o  = '0;
        end else begin
            quot_res_o = (round_up && (dvd_q != '1)) ? dvd_q + DividendW'(1) : dvd_q;
            rem_res_o  = rem_q[DivisorW-1:0];
        end
    end
`else
    // Truncated result as produced by the step in flight (the last bit).
    always_comb begin
        if (div_zero_o) begin
            quot_res_o = '1;
            rem_res_o  = '0;
        end else begin
            quot_res_o = dvd_step;
            rem_res_o  = rem_step[DivisorW-1:0];
        end
    end
`endif

endmodule

// File: rtl/video_modulator_div_u16xu8_pair.sv
// Paired iterative unsigned divider sharing one start/done handshake.
// Optional rounding stage enabled by VIDEO_MODULATOR_DIV_ROUND_EN.
module video_modulator_div_u16xu8_pair
    import video_modulator_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = VM_DIV_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = VM_DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend_1,
    input  logic [DIVISOR_W-1:0]  divisor_1,
    input  logic [DIVIDEND_W-1:0] dividend_2,
    input  logic [DIVISOR_W-1:0]  divisor_2,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient_1,
    output logic [DIVISOR_W-1:0]  remainder_1,
    output logic [DIVIDEND_W-1:0] quotient_2,
    output logic [DIVISOR_W-1:0]  remainder_2,
    output logic                  div_zero_1,
    output logic                  div_zero_2
);

    localparam int unsigned CntW = $clog2(DIVIDEND_W);

    vm_div_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic load, step, out_load;

    logic [DIVIDEND_W-1:0] l1_quot, l2_quot, q1_q, q2_q;
    logic [DIVISOR_W-1:0]  l1_rem, l2_rem, r1_q, r2_q;
    logic                  l1_zero, l2_zero, z1_q, z2_q;

    // Next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        out_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (cnt_q == '0) begin
`ifdef VIDEO_MODULATOR_DIV_ROUND_EN
                    state_d  = StRound;
`else
                    out_load = 1'b1;
                    state_d  = StDone;
`endif
                end
            end
            StRound: begin
                out_load = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                // A start here is accepted for back-to-back operation.
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= CntW'(DIVIDEND_W - 1);
            end else if (step && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Result registers, updated only on entry to StDone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            r1_q <= '0;
            z1_q <= 1'b0;
            q2_q <= '0;
            r2_q <= '0;
            z2_q <= 1'b0;
        end else if (out_load) begin
            q1_q <= l1_quot;
            r1_q <= l1_rem;
            z1_q <= l1_zero;
            q2_q <= l2_quot;
            r2_q <= l2_rem;
            z2_q <= l2_zero;
        end
    end

    video_modulator_div_lane #(
        .DividendW (DIVIDEND_W),
        .DivisorW  (DIVISOR_W)
    ) u_lane_1 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .dividend_i (dividend_1),
        .divisor_i  (divisor_1),
        .quot_res_o (l1_quot),
        .rem_res_o  (l1_rem),
        .div_zero_o (l1_zero)
    );

    video_modulator_div_lane #(
        .DividendW (DIVIDEND_W),
        .DivisorW  (DIVISOR_W)
    ) u_lane_2 (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .dividend_i (dividend_2),
        .divisor_i  (divisor_2),
        .quot_res_o (l2_quot),
        .rem_res_o  (l2_rem),
        .div_zero_o (l2_zero)
    );

    assign busy        = (state_q == StRun) || (state_q == StRound);
    assign done        = (state_q == StDone);
    assign quotient_1  = q1_q;
    assign remainder_1 = r1_q;
    assign div_zero_1  = z1_q;
    assign quotient_2  = q2_q;
    assign remainder_2 = r2_q;
    assign div_zero_2  = z2_q;

endmodule

// File: tb/tb_video_modulator_div_u16xu8_pair.sv
// Self-checking bench for video_modulator_div_u16xu8_pair.
// Follows VIDEO_MODULATOR_DIV_ROUND_EN when defined for the compile.
module tb_video_modulator_div_u16xu8_pair;

    localparam int DW = 16;
    localparam int SW = 8;
`ifdef VIDEO_MODULATOR_DIV_ROUND_EN
    localparam int Lat = DW + 2;
`else
    localparam int Lat = DW + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend_1, dividend_2;
    logic [SW-1:0] divisor_1, divisor_2;
    logic          busy, done;
    logic [DW-1:0] quotient_1, quotient_2;
    logic [SW-1:0] remainder_1, remainder_2;
    logic          div_zero_1, div_zero_2;
    logic [49:0]   obs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign obs = {quotient_1, remainder_1, div_zero_1, quotient_2, remainder_2, div_zero_2};

    video_modulator_div_u16xu8_pair dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend_1  (dividend_1),
        .divisor_1   (divisor_1),
        .dividend_2  (dividend_2),
        .divisor_2   (divisor_2),
        .busy        (busy),
        .done        (done),
        .quotient_1  (quotient_1),
        .remainder_1 (remainder_1),
        .quotient_2  (quotient_2),
        .remainder_2 (remainder_2),
        .div_zero_1  (div_zero_1),
        .div_zero_2  (div_zero_2)
    );

    // Reference: plain integer division with the zero and rounding rules.
    function automatic logic [24:0] ref_lane(input int a, input int b);
        int q, r;
        if (b == 0) return {16'hFFFF, 8'h00, 1'b1};
        q = a / b;
        r = a % b;
`ifdef VIDEO_MODULATOR_DIV_ROUND_EN
        if ((2 * r >= b) && (q < 65535)) q = q + 1;
`endif
        return {q[15:0], r[7:0], 1'b0};
    endfunction

    function automatic logic [49:0] ref_pair(input int a1, input int b1, input int a2, input int b2);
        return {ref_lane(a1, b1), ref_lane(a2, b2)};
    endfunction

    // Drive a one-cycle start; call at a falling edge, returns one cycle later.
    task automatic launch(input int a1, input int b1, input int a2, input int b2);
        start      = 1'b1;
        dividend_1 = a1[DW-1:0];
        divisor_1  = b1[SW-1:0];
        dividend_2 = a2[DW-1:0];
        divisor_2  = b2[SW-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles since the start cycle until done; bounded.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend_1 = '0; divisor_1 = '0; dividend_2 = '0; divisor_2 = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, obs} !== 52'd0)
            $display("FAIL reset_state: got %h want 0", {busy, done, obs});
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, obs} !== 52'd0)
            $display("FAIL idle_after_reset: got %h want 0", {busy, done, obs});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        int vec[5][4] = '{'{1000, 7, 65535, 255}, '{65535, 1, 0, 200}, '{1234, 0, 50, 3},
                          '{10, 4, 1000, 7}, '{65535, 2, 65535, 255}};
        logic [49:0] exp, prev;
        int cyc;
        prev = '0;
        foreach (vec[i]) begin
            exp = ref_pair(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            @(negedge clk);
            launch(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            total_cnt++;
            if (busy !== 1'b1 || obs !== prev)
                $display("FAIL dir%0d_run_hold: busy=%b obs=%h want busy=1 obs=%h", i, busy, obs, prev);
            else pass_cnt++;
            wait_done(1, cyc);
            total_cnt++;
            if (cyc != Lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, Lat);
            else pass_cnt++;
            total_cnt++;
            if (obs !== exp) $display("FAIL dir%0d_result: got %h want %h", i, obs, exp);
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
`ifdef VIDEO_MODULATOR_DIV_ROUND_EN
                if (quotient_1 !== 16'd143 || remainder_1 !== 8'd6 || quotient_2 !== 16'd257)
`else
                if (quotient_1 !== 16'd142 || remainder_1 !== 8'd6 || quotient_2 !== 16'd257)
`endif
                    $display("FAIL basic_const: got q1=%0d r1=%0d q2=%0d", quotient_1, remainder_1, quotient_2);
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL dir%0d_pulse: done=%b busy=%b want 0 0", i, done, busy);
            else pass_cnt++;
            prev = exp;
        end
    endtask

    task automatic test_ignore_start();
        logic [49:0] exp;
        int cyc, extra;
        exp = ref_pair(40000, 9, 300, 17);
        @(negedge clk);
        launch(40000, 9, 300, 17);
        repeat (4) @(negedge clk);
        launch(5, 5, 6, 6);
        wait_done(6, cyc);
        total_cnt++;
        if (cyc != Lat) $display("FAIL ignore_latency: got %0d want %0d", cyc, Lat);
        else pass_cnt++;
        total_cnt++;
        if (obs !== exp) $display("FAIL ignore_result: got %h want %h", obs, exp);
        else pass_cnt++;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL ignore_no_queue: got %0d extra done want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [49:0] exp_a, exp_b;
        int cyc;
        exp_a = ref_pair(12345, 67, 999, 0);
        exp_b = ref_pair(54321, 200, 65535, 3);
        @(negedge clk);
        launch(12345, 67, 999, 0);
        wait_done(1, cyc);
        total_cnt++;
        if (cyc != Lat || obs !== exp_a)
            $display("FAIL b2b_first: got lat=%0d %h want lat=%0d %h", cyc, obs, Lat, exp_a);
        else pass_cnt++;
        launch(54321, 200, 65535, 3);
        wait_done(1, cyc);
        total_cnt++;
        if (cyc != Lat) $display("FAIL b2b_latency: got %0d want %0d", cyc, Lat);
        else pass_cnt++;
        total_cnt++;
        if (obs !== exp_b) $display("FAIL b2b_result: got %h want %h", obs, exp_b);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [49:0] exp;
        int cyc;
        @(negedge clk);
        launch(777, 5, 888, 9);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, obs} !== 52'd0)
            $display("FAIL reset_mid: got %h want 0", {busy, done, obs});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        exp = ref_pair(4097, 13, 255, 16);
        @(negedge clk);
        launch(4097, 13, 255, 16);
        wait_done(1, cyc);
        total_cnt++;
        if (cyc != Lat || obs !== exp)
            $display("FAIL reset_recover: got lat=%0d %h want lat=%0d %h", cyc, obs, Lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [49:0] exp;
        int a1, b1, a2, b2, cyc;
        for (int i = 0; i < 1500; i++) begin
            a1 = int'($urandom_range(0, 65535));
            a2 = int'($urandom_range(0, 65535));
            b1 = (i % 37 == 0) ? 0 : int'($urandom_range(0, 255));
            b2 = (i % 41 == 0) ? 0 : int'($urandom_range(1, 255));
            exp = ref_pair(a1, b1, a2, b2);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            launch(a1, b1, a2, b2);
            wait_done(1, cyc);
            total_cnt++;
            if (cyc != Lat || obs !== exp)
                $display("FAIL rand%0d: %0d/%0d %0d/%0d got lat=%0d %h want lat=%0d %h",
                         i, a1, b1, a2, b2, cyc, obs, Lat, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
